// File: rtl/key_expansion.sv
// AES-128 key schedule generator: expands a 128-bit cipher key into 11 round keys,
// producing one full round key per clock after an accepted start.
module key_expansion (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key,
    input  logic          start,
    output logic [1407:0] out,
    output logic          finish,
    output logic          busy
);
    // state  | meaning
    // IDLE   | no schedule in progress, waiting for start
    // EXPAND | producing round keys 1..10, one per cycle
    // DONE   | out holds a complete schedule, finish asserted
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   round_cnt;
    logic [127:0] prev_rk;
    logic [127:0] next_rk;
    logic [31:0]  rot_w3, sub_w3, rcon;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic         cnt_ok, accept, step, last;

    assign cnt_ok = (round_cnt >= 4'd1) && (round_cnt <= 4'd10);
    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign step   = (state_q == EXPAND) && cnt_ok;
    assign last   = step && (round_cnt == 4'd10);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXPAND;
            EXPAND: begin
                if (!cnt_ok)                 state_d = IDLE;
                else if (round_cnt == 4'd10) state_d = DONE;
            end
            DONE:    if (start) state_d = EXPAND;
            default: state_d = IDLE;
        endcase
    end

    // Previous round key is the slot just below the one being written.
    always_comb begin
        prev_rk = '0;
        for (int r = 0; r < 10; r++) begin
            if (round_cnt == 4'(r + 1)) prev_rk = out[r*128 +: 128];
        end
    end

    always_comb begin
        case (round_cnt)
            4'd1:    rcon = 32'h0100_0000;
            4'd2:    rcon = 32'h0200_0000;
            4'd3:    rcon = 32'h0400_0000;
            4'd4:    rcon = 32'h0800_0000;
            4'd5:    rcon = 32'h1000_0000;
            4'd6:    rcon = 32'h2000_0000;
            4'd7:    rcon = 32'h4000_0000;
            4'd8:    rcon = 32'h8000_0000;
            4'd9:    rcon = 32'h1b00_0000;
            4'd10:   rcon = 32'h3600_0000;
            default: rcon = 32'h0000_0000;
        endcase
    end

    assign rot_w3 = {prev_rk[23:0], prev_rk[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        key_expansion_sbox u_sbox (
            .a (rot_w3[8*i +: 8]),
            .q (sub_w3[8*i +: 8])
        );
    end

    assign w0n     = prev_rk[127:96] ^ sub_w3 ^ rcon;
    assign w1n     = prev_rk[95:64] ^ w0n;
    assign w2n     = prev_rk[63:32] ^ w1n;
    assign w3n     = prev_rk[31:0]  ^ w2n;
    assign next_rk = {w0n, w1n, w2n, w3n};

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            finish    <= 1'b0;
            busy      <= 1'b0;
            round_cnt <= 4'd0;
        end else if (accept) begin
            out       <= {1280'd0, key};
            round_cnt <= 4'd1;
            busy      <= 1'b1;
            finish    <= 1'b0;
        end else if (step) begin
            for (int r = 1; r <= 10; r++) begin
                if (round_cnt == 4'(r)) out[r*128 +: 128] <= next_rk;
            end
            if (last) begin
                busy      <= 1'b0;
                finish    <= 1'b1;
                round_cnt <= 4'd0;
            end else begin
                round_cnt <= round_cnt + 4'd1;
            end
        end else if (state_q == EXPAND) begin
            // Corrupted counter: drop back to idle rather than write a bogus slot.
            busy      <= 1'b0;
            round_cnt <= 4'd0;
        end
    end
endmodule

// Combinational AES forward S-box; row-major table, entry 0 leftmost.
module key_expansion_sbox (
    input  logic [7:0] a,
    output logic [7:0] q
);
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign q = SBOX_TABLE[a];
endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: FIPS-197 vectors, control corner cases and
// random keys against a word-level key schedule model with a GF(2^8)-derived S-box.
module tb_key_expansion;
    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  key;
    logic          start;
    logic [1407:0] out;
    logic          finish;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int overlap  = 0;
    logic [7:0] sbox_tab [256];

    localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expansion dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .start  (start),
        .out    (out),
        .finish (finish),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && finish) overlap++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] ref_sched(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] s = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t ^= {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) s[(i/4)*128 + (3 - i%4)*32 +: 32] = w[i];
        return s;
    endfunction

    task automatic check_sched(input string tag, input logic [127:0] k);
        logic [1407:0] exp;
        exp = ref_sched(k);
        for (int r = 0; r <= 10; r++)
            check($sformatf("%s_rk%0d", tag, r), out[r*128 +: 128], exp[r*128 +: 128]);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Entered and left at 1ns after a rising edge. poke_cyc >= 0 re-pulses start
    // with a foreign key after that many EXPAND edges; key is scrambled every cycle.
    task automatic run_expand(input string tag, input logic [127:0] k, input int poke_cyc,
                              output int lat);
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key   = rand_key();
        check({tag, "_start_busy"}, {127'd0, busy}, 128'd1);
        check({tag, "_start_finish"}, {127'd0, finish}, 128'd0);
        check({tag, "_start_rk0"}, out[127:0], k);
        check({tag, "_unwritten_rk1"}, out[255:128], 128'd0);
        lat = 0;
        while (!finish && lat < 20) begin
            if (lat == poke_cyc) begin
                start = 1'b1;
                key   = rand_key();
            end
            @(posedge clk); #1;
            if (lat == poke_cyc) check({tag, "_poke_busy"}, {127'd0, busy}, 128'd1);
            start = 1'b0;
            key   = rand_key();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'd10);
    endtask

    initial begin
        int lat;
        rst   = 1'b1;
        start = 1'b0;
        key   = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_finish", {127'd0, finish}, 128'd0);
        check("reset_out_zero", {127'd0, |out}, 128'd0);
        rst = 1'b0;

        run_expand("a1", KEY_A1, -1, lat);
        check("a1_const_rk0", out[127:0], KEY_A1);
        check("a1_const_rk1", out[255:128], A1_RK1);
        check("a1_const_rk10", out[1407:1280], A1_RK10);
        check_sched("a1", KEY_A1);

        repeat (3) @(posedge clk);
        #1;
        check("done_hold_finish", {127'd0, finish}, 128'd1);
        check("done_hold_busy", {127'd0, busy}, 128'd0);
        check_sched("done_hold", KEY_A1);

        run_expand("zero", 128'd0, -1, lat);
        check("zero_const_rk1", out[255:128], ZERO_RK1);
        check("zero_const_rk10", out[1407:1280], ZERO_RK10);
        check_sched("zero", 128'd0);

        run_expand("ignored", KEY_A1, 3, lat);
        check_sched("ignored", KEY_A1);

        key   = 128'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_zero", {127'd0, |out}, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_finish", {127'd0, finish}, 128'd0);
        @(posedge clk); #1;
        check("abort_idle_busy", {127'd0, busy}, 128'd0);
        run_expand("after_abort", KEY_A1, -1, lat);
        check("after_abort_rk1", out[255:128], A1_RK1);
        check("after_abort_rk10", out[1407:1280], A1_RK10);

        rst   = 1'b1;
        start = 1'b1;
        key   = rand_key();
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("prio_busy", {127'd0, busy}, 128'd0);
        check("prio_finish", {127'd0, finish}, 128'd0);
        check("prio_out_zero", {127'd0, |out}, 128'd0);
        @(posedge clk); #1;
        check("prio_idle_busy", {127'd0, busy}, 128'd0);

        for (int i = 0; i < 5; i++) begin
            logic [127:0] k;
            k = rand_key();
            run_expand($sformatf("rand%0d", i), k, -1, lat);
            check_sched($sformatf("rand%0d", i), k);
        end

        check("busy_finish_overlap", 128'(overlap), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (Nk=4, Nr=10, 11 round keys).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 key  input  128  cipher key, sampled only on an accepted start.
REQ-005 start  input  1  request a new expansion, single-cycle pulse or level.
REQ-006 out  output reg  1408  expanded key; round key r in bits [r*128+127 : r*128], r = 0..10.
REQ-007 finish  output reg  1  high while `out` holds a complete, valid schedule.
REQ-008 busy  output reg  1  high while expansion is in progress.

Function
REQ-009 Word order SHALL follow FIPS-197 within each round key: w[4r] in bits [r*128+127 : r*128+96] and w[4r+3] in bits [r*128+31 : r*128]. Byte 0 of each word SHALL be its MSB.
REQ-010 The FSM SHALL have three states: IDLE, EXPAND and DONE. Reset SHALL enter IDLE.
REQ-011 IDLE with start=1 at edge N SHALL take these actions at that edge:
- write key into out[127:0];
- clear out[1407:128];
- set round counter to 1;
- set busy=1 and finish=0;
- go to EXPAND.
REQ-012 In EXPAND, each cycle SHALL compute one full round key from the previous one and write it at edge N+r, for r = 1..10.
REQ-013 Round key computation SHALL be:
- w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r];
- w1' = w1 ^ w0';
- w2' = w2 ^ w1';
- w3' = w3 ^ w2'.
REQ-014 Rcon[r] SHALL be {rc,24'h0} with rc = 01,02,04,08,10,20,40,80,1B,36 for r = 1..10.
REQ-015 SubWord SHALL apply the AES forward S-box to each of the 4 bytes. The S-box SHALL be combinational, 4 instances.
REQ-016 At edge N+10 the block SHALL do all of the following:
- write round key 10;
- set busy=0 and finish=1;
- go to DONE.
Total latency from accepted start to finish=1 is 10 cycles after the start edge.
REQ-017 In DONE, out and finish SHALL hold until the next accepted start or rst.
REQ-018 start=1 in DONE SHALL behave as in IDLE: restart, finish drops to 0 at that edge.
REQ-019 start while in EXPAND SHALL be ignored. key changes during EXPAND SHALL have no effect.
REQ-020 Round key slots not yet written during EXPAND SHALL read 0. Consumers SHALL qualify `out` with finish.
REQ-021 The round counter SHALL be 4 bits and SHALL never exceed 10. Values 11..15 are unreachable and SHALL map to IDLE.
REQ-022 finish and busy SHALL never be 1 simultaneously.

Reset
REQ-023 rst=1 at any edge SHALL have priority over start. It SHALL set out=0, finish=0, busy=0, round counter 0, state IDLE.
REQ-024 rst during EXPAND SHALL abort the expansion. No partial schedule SHALL remain visible; out reads 0.
REQ-025 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-026 FIPS-197 A.1 vector:
- key=2b7e151628aed2a6abf7158809cf4f3c, start pulse;
- finish=1 exactly 10 cycles after the start edge;
- round 1 = a0fafe1788542cb123a339392a6c7605;
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
- round 0 = key.
REQ-027 All-zero key:
- round 1 = 62636363626363636263636362636363;
- round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-028 Ignored start and key change:
- start at cycle 3 of EXPAND with a different key;
- busy stays 1, schedule equals that of the original key, finish still at start+10.
REQ-029 Reset mid-expansion:
- rst at cycle 5 of EXPAND;
- next cycle out=0, finish=0, busy=0;
- a new start then completes the A.1 vector in 10 cycles.
REQ-030 Restart from DONE:
- after the A.1 result, start with the all-zero key;
- finish drops at the start edge and returns 10 cycles later with the REQ-027 values.
REQ-031 Reset priority: rst=1 and start=1 on the same edge -> state IDLE, busy=0, out=0.
